hs_ready_sink: RTL and testbench
================================

# hs_ready_sink

Receiving end of the valid/ready handshake: accepts beats from an upstream sender that honours `ready_out`, buffers them in a small FIFO, and drains them at a fixed throttled rate into a running sum and beat count. `ready_out` is driven straight from a flop, so the sender sees a clean registered ready. This block is the downstream partner for the handshake sender, and serves as the bench consumer for that sender.

## Interface
- `DATA_W`, 3, beat payload width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `DRAIN_DIV`, 2, cycles per drain opportunity; ≥1

- `sys_clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `valid_in`  in  1  sender has a beat on `data_in`
- `data_in`  in  DATA_W  beat payload
- `ready_out`  out  1  registered; sink can take a beat this cycle
- `drain_valid`  out  1  one-cycle pulse per popped beat
- `drain_data`  out  DATA_W  popped payload; valid while `drain_valid`=1
- `sum`  out  8  running sum of drained payloads, mod 256
- `count`  out  8  drained beat count, mod 256
- `err_cnt`  out  4  protocol violation count; present only with `HS_SINK_ERR_EN`

## Operation
- Accept: `acc = valid_in & ready_out`. On `acc`, write `data_in` at the write pointer and advance the pointer, wrapping modulo `DEPTH`.
- Occupancy `occ` runs 0..DEPTH. `occ_next = occ + acc - pop`.
- `ready_out` flop loads `(occ_next < DEPTH)` each cycle, so a full FIFO never receives an accept.
- Divider `div` counts 0..DRAIN_DIV-1 and wraps; it runs free. `tick = (div == DRAIN_DIV-1)`.
- Pop: `pop = tick & (occ != 0)`. On pop, register the head entry into `drain_data`, pulse `drain_valid` for one cycle, set `sum += head` (zero-extended, wraps at 256), set `count += 1` (wraps), and advance the read pointer.
- Push and pop in the same cycle: both pointers advance and `occ` is unchanged. This is legal at `occ = DEPTH`, but there `ready_out` is already 0, so no push can occur.
- Empty with `tick`: no pop, and `drain_valid` stays 0.
- Order is strictly FIFO. The block never drops or duplicates a beat.

## Timing
- Reset, while `rst`=1 at an edge: pointers, `occ`, `div`, `drain_valid`, `drain_data`, `sum`, `count`, and `err_cnt` are all cleared to 0. `ready_out` is 0.
- First edge after `rst` falls: `ready_out` becomes 1.
- Latency: a beat accepted at edge N enters the FIFO at N. It can be popped no earlier than edge N+1, at the first `tick`. `drain_valid` and `drain_data` appear in the cycle after that pop edge.
- Worst-case accept-to-drain latency with an empty FIFO is DRAIN_DIV cycles.
- Reset mid-operation flushes all queued beats, with no drain pulses for them. `sum` and `count` are cleared.
- The sender may change `data_in` freely when `valid_in`=0. While `valid_in`=1 and `ready_out`=0, the sender must hold `valid_in` and `data_in` stable.

## Configuration
- `HS_SINK_ERR_EN` defined:
  - A violation is any cycle in which the previous cycle had `valid_in`=1 and `ready_out`=0, and this cycle has `valid_in`=0 or a changed `data_in`.
  - Each violation increments `err_cnt`, which saturates at 15.
  - The sink accepts whatever is presented; errors are counted only.
- `HS_SINK_ERR_EN` undefined: the `err_cnt` port and all checker flops are absent. Behaviour is otherwise identical.

## Test plan
All scenarios use the defaults `DEPTH`=4 and `DRAIN_DIV`=2.
- Reset: hold `rst`=1 for 2 cycles with `valid_in`=1 → `ready_out`=0, `drain_valid`=0, `sum`=0, `count`=0. `ready_out`=1 on the first edge after release.
- Single beat: `valid_in`=1 with `data_in`=5 for one accepted cycle → exactly one `drain_valid` pulse with `drain_data`=5 within 2 cycles. Then `sum`=5, `count`=1.
- Backpressure: `valid_in` held at 1 with `data_in` stepping 1..7 on each accept → `ready_out` falls once `occ` reaches 4. Drain order is 1,2,…,7, ending at `sum`=28, `count`=7, with no loss and no duplicates.
- Wrap: 40 accepted beats of 7 → `sum`=24 (280 mod 256), `count`=40.
- Mid-op reset: queue 3 beats, then assert `rst` for 1 cycle → no `drain_valid` afterwards, `sum`=0, `count`=0, `ready_out`=1 the cycle after release.
- `HS_SINK_ERR_EN`: hold `valid_in`=1 with `data_in`=3 while `ready_out`=0, then change to 6 before acceptance → `err_cnt`=1. Do the same with `HS_SINK_ERR_EN` undefined → draining is identical.

Source files
------------

// File: rtl/hs_ready_sink.sv
// hs_ready_sink: receiving end of a valid/ready handshake.
// Accepts beats while the registered ready_out is high, queues them in a
// DEPTH-entry FIFO and drains one beat every DRAIN_DIV cycles into a running
// sum and beat count.
// Optional build macro HS_SINK_ERR_EN adds the err_cnt port and a checker that
// counts senders dropping valid_in or changing data_in while stalled.
module hs_ready_sink #(
  parameter int DATA_W    = 3,
  parameter int DEPTH     = 4,
  parameter int DRAIN_DIV = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              drain_valid,
  output logic [DATA_W-1:0] drain_data,
  output logic [7:0]        sum,
  output logic [7:0]        count
`ifdef HS_SINK_ERR_EN
  ,
  output logic [3:0]        err_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  // Storage and state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              ready_q, ready_d;
  logic              drain_valid_q, drain_valid_d;
  logic [DATA_W-1:0] drain_data_q, drain_data_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        count_q, count_d;

  // Handshake and drain strobes
  logic              acc;
  logic              tick;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign acc  = valid_in & ready_q;
  assign tick = (div_q == DIV_W'(DRAIN_DIV - 1));
  assign pop  = tick & (occ_q != '0);
  assign head = mem_q[rd_ptr_q];

  // Next-state logic for pointers, occupancy, divider, ready and drain outputs
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    drain_valid_d = 1'b0;
    drain_data_d  = drain_data_q;
    sum_d         = sum_q;
    count_d       = count_q;

    div_d = tick ? '0 : div_q + DIV_W'(1);
    occ_d = occ_q + OCC_W'(acc) - OCC_W'(pop);
    // Ready is computed from next occupancy so a full FIFO is never offered.
    ready_d = (occ_d < OCC_W'(DEPTH));

    if (acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d      = rd_ptr_q + PTR_W'(1);
      drain_valid_d = 1'b1;
      drain_data_d  = head;
      sum_d         = sum_q + 8'(head);
      count_d       = count_q + 8'd1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      div_q         <= '0;
      ready_q       <= 1'b0;
      drain_valid_q <= 1'b0;
      drain_data_q  <= '0;
      sum_q         <= '0;
      count_q       <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      div_q         <= div_d;
      ready_q       <= ready_d;
      drain_valid_q <= drain_valid_d;
      drain_data_q  <= drain_data_d;
      sum_q         <= sum_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage write on accept
  always_ff @(posedge sys_clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy and the
    // pointers decide which entries are meaningful, so stale data is harmless.
    if (acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign ready_out   = ready_q;
  assign drain_valid = drain_valid_q;
  assign drain_data  = drain_data_q;
  assign sum         = sum_q;
  assign count       = count_q;

`ifdef HS_SINK_ERR_EN
  // Protocol checker: a stalled beat must stay valid with unchanged payload.
  logic              stall_q;
  logic [DATA_W-1:0] held_data_q;
  logic [3:0]        err_q;
  logic              viol;

  assign viol = stall_q & (~valid_in | (data_in != held_data_q));

  // Remember last cycle's stall and payload; count violations, saturating at 15
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      stall_q     <= 1'b0;
      held_data_q <= '0;
      err_q       <= '0;
    end else begin
      stall_q     <= valid_in & ~ready_q;
      held_data_q <= data_in;
      if (viol && (err_q != 4'd15)) begin
        err_q <= err_q + 4'd1;
      end
    end
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_hs_ready_sink.sv
// Directed testbench for hs_ready_sink with DEPTH=4, DRAIN_DIV=2, DATA_W=3.
// Inputs are driven and outputs checked on the falling clock edge; drained
// beats are collected on the rising edge from the value held since the
// previous edge.
module tb_hs_ready_sink;

  localparam int DW = 3;

  logic          sys_clk = 1'b0;
  logic          rst     = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ready_out;
  logic          drain_valid;
  logic [DW-1:0] drain_data;
  logic [7:0]    sum;
  logic [7:0]    count;
`ifdef HS_SINK_ERR_EN
  logic [3:0]    err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] drained [$];
  logic [DW-1:0] expq    [$];

  always #5 sys_clk = ~sys_clk;

  hs_ready_sink #(
    .DATA_W   (DW),
    .DEPTH    (4),
    .DRAIN_DIV(2)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ready_out  (ready_out),
    .drain_valid(drain_valid),
    .drain_data (drain_data),
    .sum        (sum),
    .count      (count)
`ifdef HS_SINK_ERR_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  // Collect drained payloads (pre-edge values are stable at the rising edge)
  always @(posedge sys_clk) begin
    if (drain_valid) drained.push_back(drain_data);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    valid_in = 1'b0;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    drained.delete();
    expq.delete();
  endtask

  // Present a beat from a falling edge and hold it until accepted; returns at
  // the falling edge after the accepting edge with valid_in still high.
  task automatic send_beat(input logic [DW-1:0] d);
    int waited;
    waited = 0;
    valid_in = 1'b1;
    data_in  = d;
    while (!ready_out && waited < 50) begin
      cycles(1);
      waited++;
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout beat=%0d ready_out=%b expected 1", d, ready_out);
    end else begin
      expq.push_back(d);
      cycles(1);
    end
  endtask

  task automatic compare_drained(input string name);
    checks++;
    if (drained.size() != expq.size()) begin
      errors++;
      $display("FAIL %s_len got %0d expected %0d", name, drained.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        checks++;
        if (drained[i] !== expq[i]) begin
          errors++;
          $display("FAIL %s_beat%0d got %0d expected %0d", name, i, drained[i], expq[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    rst = 1'b1;
    valid_in = 1'b1;
    data_in = 3'd2;
    cycles(2);
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", ready_out); end
    checks++;
    if (drain_valid !== 1'b0) begin errors++; $display("FAIL reset_drain_valid got %b expected 0", drain_valid); end
    checks++;
    if (sum !== 8'd0) begin errors++; $display("FAIL reset_sum got %0d expected 0", sum); end
    checks++;
    if (count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
`ifdef HS_SINK_ERR_EN
    checks++;
    if (err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err_cnt got %0d expected 0", err_cnt); end
`endif
    rst = 1'b0;
    cycles(1);
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b expected 1", ready_out); end
    valid_in = 1'b0;
  endtask

  task automatic test_single_beat();
    int first;
    int pulses;
    logic [DW-1:0] seen;
    do_reset();
    send_beat(3'd5);
    valid_in = 1'b0;
    first  = 0;
    pulses = 0;
    seen   = '0;
    for (int k = 1; k <= 6; k++) begin
      cycles(1);
      if (drain_valid === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = k;
          seen = drain_data;
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL single_pulses got %0d expected 1", pulses); end
    checks++;
    if (first < 1 || first > 2) begin errors++; $display("FAIL single_latency got %0d expected 1..2", first); end
    checks++;
    if (seen !== 3'd5) begin errors++; $display("FAIL single_data got %0d expected 5", seen); end
    checks++;
    if (sum !== 8'd5) begin errors++; $display("FAIL single_sum got %0d expected 5", sum); end
    checks++;
    if (count !== 8'd1) begin errors++; $display("FAIL single_count got %0d expected 1", count); end
  endtask

  task automatic test_backpressure();
    logic saw_low;
    do_reset();
    saw_low = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      send_beat(DW'(i));
      if (ready_out === 1'b0) saw_low = 1'b1;
    end
    valid_in = 1'b0;
    cycles(20);
    checks++;
    if (saw_low !== 1'b1) begin errors++; $display("FAIL bp_ready_fell got %b expected 1", saw_low); end
    compare_drained("bp");
    checks++;
    if (sum !== 8'd28) begin errors++; $display("FAIL bp_sum got %0d expected 28", sum); end
    checks++;
    if (count !== 8'd7) begin errors++; $display("FAIL bp_count got %0d expected 7", count); end
`ifdef HS_SINK_ERR_EN
    checks++;
    if (err_cnt !== 4'd0) begin errors++; $display("FAIL bp_err_cnt got %0d expected 0", err_cnt); end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 40; i++) send_beat(3'd7);
    valid_in = 1'b0;
    cycles(20);
    checks++;
    if (sum !== 8'd24) begin errors++; $display("FAIL wrap_sum got %0d expected 24", sum); end
    checks++;
    if (count !== 8'd40) begin errors++; $display("FAIL wrap_count got %0d expected 40", count); end
    compare_drained("wrap");
  endtask

  task automatic test_midop_reset();
    do_reset();
    send_beat(3'd1);
    send_beat(3'd2);
    send_beat(3'd3);
    valid_in = 1'b0;
    rst = 1'b1;
    cycles(1);
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL midrst_ready_in_reset got %b expected 0", ready_out); end
    drained.delete();
    expq.delete();
    rst = 1'b0;
    cycles(1);
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL midrst_ready_release got %b expected 1", ready_out); end
    cycles(10);
    checks++;
    if (drained.size() != 0) begin errors++; $display("FAIL midrst_no_drain got %0d pulses expected 0", drained.size()); end
    checks++;
    if (sum !== 8'd0) begin errors++; $display("FAIL midrst_sum got %0d expected 0", sum); end
    checks++;
    if (count !== 8'd0) begin errors++; $display("FAIL midrst_count got %0d expected 0", count); end
    send_beat(3'd4);
    valid_in = 1'b0;
    cycles(8);
    compare_drained("midrst_after");
    checks++;
    if (sum !== 8'd4) begin errors++; $display("FAIL midrst_after_sum got %0d expected 4", sum); end
  endtask

  // Stall the sender with payload 3, then switch to 6 before it is accepted.
  task automatic test_protocol_violation();
    int i;
    do_reset();
    i = 1;
    send_beat(DW'(i));
    while (ready_out !== 1'b0 && i < 12) begin
      i++;
      send_beat(DW'(i));
    end
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL viol_fill ready_out got %b expected 0", ready_out); end
    data_in = 3'd3;
    cycles(1);
    send_beat(3'd6);
    valid_in = 1'b0;
    cycles(20);
    compare_drained("viol");
`ifdef HS_SINK_ERR_EN
    checks++;
    if (err_cnt !== 4'd1) begin errors++; $display("FAIL viol_err_cnt got %0d expected 1", err_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_wrap();
    test_midop_reset();
    test_protocol_violation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
